// File: rtl/op_fetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package op_fetch_pkg;

   localparam logic [15:0] RST_VEC_DEF = 16'h0000;
   localparam int          DEPTH_DEF   = 4;

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_REQ   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Byte count must be able to hold the value DEPTH itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/op_fetch_if.sv
// ROM request/ack bus plus the decode-facing view of the prefetch stage.
// rom_req/rom_ack: a request holds rom_req=1 with a stable rom_addr until the
// cycle rom_ack=1, which completes it and carries rom_data; pc_wr or rst cancel it.
interface op_fetch_if;

   logic [15:0]           pc_in;
   logic                  pc_wr;
   logic                  rd;
   logic [1:0]            rd_len;
   logic [15:0]           rom_addr;
   logic                  rom_req;
   logic [7:0]            rom_data;
   logic                  rom_ack;
   logic [7:0]            op1;
   logic [7:0]            op2;
   logic [7:0]            op3;
   logic                  op_valid;
   logic [15:0]           pc_out;
   op_fetch_pkg::state_t  state;

   modport master (
      input  pc_in, pc_wr, rd, rd_len, rom_data, rom_ack,
      output rom_addr, rom_req, op1, op2, op3, op_valid, pc_out, state
   );

   modport slave (
      output pc_in, pc_wr, rd, rd_len, rom_data, rom_ack,
      input  rom_addr, rom_req, op1, op2, op3, op_valid, pc_out, state
   );

endinterface

// File: rtl/op_fetch_fetch_queue.sv
// Byte shift queue: slot 0 is the oldest byte, vacated slots refill with 8'h00.
module fetch_queue
   import op_fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic [1:0]    pop_n,
   input  logic          flush,
   output logic [7:0]    q0,
   output logic [7:0]    q1,
   output logic [7:0]    q2,
   output logic [CW-1:0] count
);

   localparam int EW = $clog2(DEPTH + 3);
   localparam int EN = 2 ** EW;

   logic [7:0]    mem [DEPTH];
   logic [7:0]    ext [EN];
   logic [7:0]    nxt [DEPTH];
   logic [EW-1:0] src;
   logic [CW-1:0] wr_idx;
   logic [CW-1:0] cnt_nxt;

   // Zero-padded copy lets a pop of up to 3 shift zeros in without bounds checks.
   always_comb begin
      for (int j = 0; j < EN; j++) ext[j] = 8'h00;
      for (int j = 0; j < DEPTH; j++) ext[j] = mem[j];
      wr_idx  = count - CW'(pop_n);
      cnt_nxt = wr_idx + CW'(push);
      src     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         src    = EW'(i) + EW'(pop_n);
         nxt[i] = (push && (wr_idx == CW'(i))) ? push_data : ext[src];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         count <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= nxt[i];
         count <= cnt_nxt;
      end
   end

   assign q0 = mem[0];
   assign q1 = mem[1];
   assign q2 = mem[2];

endmodule

// File: rtl/op_fetch.sv
// Instruction prefetch: fills a byte queue from ROM and presents op1..op3 at pc_out.
module op_fetch
   import op_fetch_pkg::*;
#(
   parameter int          DEPTH   = DEPTH_DEF,
   parameter logic [15:0] RST_VEC = RST_VEC_DEF
) (
   input logic        clk,
   input logic        rst,
   op_fetch_if.master bus
);

   localparam int CW = cnt_w(DEPTH);

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   fetch_addr;
   logic [15:0]   pc_q;
   logic [CW-1:0] count;
   logic [CW-1:0] cnt_after;
   logic [1:0]    len;
   logic [1:0]    pop_n;
   logic          push;
   logic          pop;
   logic          valid;

   assign valid = (count >= CW'(3));

   // pc_wr overrides both the consumer and any ack arriving in the same cycle.
   always_comb begin
      len       = (bus.rd_len == 2'd0) ? 2'd1 : bus.rd_len;
      pop       = bus.rd & valid & ~bus.pc_wr;
      push      = (state == ST_REQ) & bus.rom_ack & ~bus.pc_wr;
      pop_n     = pop ? len : 2'd0;
      cnt_after = count - CW'(pop_n) + CW'(push);
      state_nxt = state;
      if (bus.pc_wr) begin
         state_nxt = ST_FLUSH;
      end else begin
         case (state)
            ST_FLUSH: state_nxt = ST_REQ;
            ST_REQ:   state_nxt = (cnt_after < CW'(DEPTH)) ? ST_REQ : ST_FULL;
            ST_FULL:  state_nxt = pop ? ST_REQ : ST_FULL;
            default:  state_nxt = ST_FLUSH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_FLUSH;
         fetch_addr <= RST_VEC;
         pc_q       <= RST_VEC;
      end else begin
         state <= state_nxt;
         if (bus.pc_wr) begin
            fetch_addr <= bus.pc_in;
            pc_q       <= bus.pc_in;
         end else begin
            if (push) fetch_addr <= fetch_addr + 16'd1;
            if (pop)  pc_q       <= pc_q + 16'(len);
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.rom_data),
      .pop_n     (pop_n),
      .flush     (bus.pc_wr),
      .q0        (bus.op1),
      .q1        (bus.op2),
      .q2        (bus.op3),
      .count     (count)
   );

   assign bus.rom_req  = (state == ST_REQ);
   assign bus.rom_addr = fetch_addr;
   assign bus.op_valid = valid;
   assign bus.pc_out   = pc_q;
   assign bus.state    = state;

endmodule
